// File: rtl/baby_kyber_pkg.sv
// baby_kyber_pkg -- shared constants and types for the toy Kyber decryption
// datapath.
//   Q       : ciphertext modulus
//   N       : polynomial length (ring Z_Q[x]/(x^N+1))
//   K       : module rank (number of polynomials in s and u)
//   RND_LO / RND_HI : reduced coefficient window that decodes to a 1 bit
//   coeff_t : raw signed input coefficient
//   acc_t   : signed multiply-accumulate register
//   state_t : decrypt controller states
package baby_kyber_pkg;

  localparam int Q      = 17;
  localparam int N      = 4;
  localparam int K      = 2;
  localparam int RND_LO = 5;
  localparam int RND_HI = 13;

  typedef logic signed [31:0] coeff_t;
  typedef logic signed [15:0] acc_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/coeff_mod_q.sv
// coeff_mod_q -- combinational true-modulo reduction of a signed coefficient
// into [0, Q-1]. Negative inputs wrap upward rather than keeping the sign of
// the dividend as the plain % operator would.
//   value   : signed coefficient to reduce
//   reduced : value mod Q, always in [0, Q-1]
module coeff_mod_q #(
  parameter int Q = baby_kyber_pkg::Q
) (
  input  baby_kyber_pkg::coeff_t value,
  output baby_kyber_pkg::coeff_t reduced
);
  import baby_kyber_pkg::*;

  localparam coeff_t QC = coeff_t'(Q);

  coeff_t remainder;

  always_comb begin
    remainder = value % QC;
    reduced   = (remainder < 0) ? remainder + QC : remainder;
  end

endmodule

// File: rtl/decrypt_ctrl.sv
// decrypt_ctrl -- toy Kyber decryption: mn = v - (s_0*u_0 + s_1*u_1) in
// Z_Q[x]/(x^4+1) through one shared multiply-accumulate unit, then each
// coefficient is rounded to a message bit.
//   clk, rst       : clock, asynchronous active-high reset
//   in_valid/in_ready   : request handshake (accepted only in IDLE)
//   secret_key[r][n]    : s_r coefficients
//   ciphertext[0][r][n] : u_r coefficients; ciphertext[1][0][n] : v;
//                         ciphertext[1][1] is ignored
//   out_valid/out_ready : result handshake
//   m_b            : decoded message bits
//   decimal_value  : 8*m_b[0] + 4*m_b[1] + 2*m_b[2] + m_b[3]
//   mn_out         : reduced noisy coefficients, present only when the macro
//                    DECRYPT_CTRL_NOISY_OUT_EN is defined
module decrypt_ctrl #(
  parameter int Q      = baby_kyber_pkg::Q,
  parameter int RND_LO = baby_kyber_pkg::RND_LO,
  parameter int RND_HI = baby_kyber_pkg::RND_HI
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  baby_kyber_pkg::coeff_t secret_key [1:0][3:0],
  input  baby_kyber_pkg::coeff_t ciphertext [1:0][1:0][3:0],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             m_b,
  output logic [3:0]             decimal_value
`ifdef DECRYPT_CTRL_NOISY_OUT_EN
  ,
  output logic [4:0]             mn_out [3:0]
`endif
);
  import baby_kyber_pkg::*;

  state_t       state_reg, state_next;
  acc_t         s_reg   [K][N];
  acc_t         u_reg   [K][N];
  acc_t         acc_reg [N];
  logic         r_reg;
  logic [1:0]   i_reg, j_reg;
  logic [3:0]   m_b_reg, decimal_reg;
  logic         out_valid_reg;

  coeff_t       s_red   [K][N];
  coeff_t       u_red   [K][N];
  coeff_t       v_red   [N];
  coeff_t       acc_red [N];
  logic [N-1:0] bit_dec;

  logic         capture, mac_en, reduce_en, mac_last, out_fire;
  logic [2:0]   k;
  acc_t         prod;
  logic         unused_bits;

  // Input reduction at capture and accumulator reduction at REDUCE.
  genvar gi, gr;
  generate
    for (gr = 0; gr < K; gr++) begin : g_poly
      for (gi = 0; gi < N; gi++) begin : g_coef
        coeff_mod_q #(.Q(Q)) u_s_mod (.value(secret_key[gr][gi]),    .reduced(s_red[gr][gi]));
        coeff_mod_q #(.Q(Q)) u_u_mod (.value(ciphertext[0][gr][gi]), .reduced(u_red[gr][gi]));
      end
    end
    for (gi = 0; gi < N; gi++) begin : g_lane
      coeff_mod_q #(.Q(Q)) u_v_mod   (.value(ciphertext[1][0][gi]), .reduced(v_red[gi]));
      coeff_mod_q #(.Q(Q)) u_acc_mod (.value(coeff_t'(acc_reg[gi])), .reduced(acc_red[gi]));
      assign bit_dec[gi] = (acc_red[gi] >= RND_LO) && (acc_red[gi] <= RND_HI);
    end
  endgenerate

  // Reduced values are below Q, so only the low half of each reduction is
  // stored; the upper halves and the unused ciphertext slot are tied off here.
  always_comb begin
    unused_bits = 1'b0;
    for (int n = 0; n < N; n++) begin
      unused_bits = unused_bits ^ (^ciphertext[1][1][n]) ^ (^v_red[n][31:16]);
      for (int r = 0; r < K; r++) begin
        unused_bits = unused_bits ^ (^s_red[r][n][31:16]) ^ (^u_red[r][n][31:16]);
      end
    end
  end

  // Shared MAC: p = s_r[j]*u_r[i] lands on coefficient i+j; the x^4 = -1 wrap
  // flips the sign, so k<4 subtracts and k>=4 adds into acc[k-4].
  assign k        = {1'b0, i_reg} + {1'b0, j_reg};
  assign prod     = s_reg[r_reg][j_reg] * u_reg[r_reg][i_reg];
  assign mac_last = r_reg & (&i_reg) & (&j_reg);
  assign capture  = in_valid && in_ready;
  assign out_fire = out_valid_reg && out_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (capture)  state_next = MAC;
      MAC:     if (mac_last) state_next = REDUCE;
      REDUCE:  state_next = DONE;
      DONE:    if (out_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready  = 1'b0;
    mac_en    = 1'b0;
    reduce_en = 1'b0;
    case (state_reg)
      IDLE:    in_ready  = 1'b1;
      MAC:     mac_en    = 1'b1;
      REDUCE:  reduce_en = 1'b1;
      default: ;
    endcase
  end

  // Datapath. out_valid is registered off the DONE state, so it rises on the
  // second DONE cycle (34 cycles after the handshake) and drops on the same
  // edge that returns the FSM to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < N; n++) begin
        acc_reg[n] <= '0;
        for (int r = 0; r < K; r++) begin
          s_reg[r][n] <= '0;
          u_reg[r][n] <= '0;
        end
      end
      r_reg         <= 1'b0;
      i_reg         <= 2'd0;
      j_reg         <= 2'd0;
      m_b_reg       <= 4'd0;
      decimal_reg   <= 4'd0;
      out_valid_reg <= 1'b0;
    end else begin
      if (capture) begin
        for (int n = 0; n < N; n++) begin
          acc_reg[n] <= v_red[n][15:0];
          for (int r = 0; r < K; r++) begin
            s_reg[r][n] <= s_red[r][n][15:0];
            u_reg[r][n] <= u_red[r][n][15:0];
          end
        end
        {r_reg, i_reg, j_reg} <= 5'd0;
      end else if (mac_en) begin
        if (k[2]) acc_reg[k[1:0]] <= acc_reg[k[1:0]] + prod;
        else      acc_reg[k[1:0]] <= acc_reg[k[1:0]] - prod;
        {r_reg, i_reg, j_reg} <= {r_reg, i_reg, j_reg} + 5'd1;
      end
      if (reduce_en) begin
        m_b_reg     <= bit_dec;
        decimal_reg <= {bit_dec[0], bit_dec[1], bit_dec[2], bit_dec[3]};
      end
      out_valid_reg <= (state_reg == DONE) && !out_fire;
    end
  end

  assign out_valid     = out_valid_reg;
  assign m_b           = m_b_reg;
  assign decimal_value = decimal_reg;

`ifdef DECRYPT_CTRL_NOISY_OUT_EN
  logic [4:0] mn_reg [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < N; n++) mn_reg[n] <= 5'd0;
    end else if (reduce_en) begin
      for (int n = 0; n < N; n++) mn_reg[n] <= acc_red[n][4:0];
    end
  end

  assign mn_out = mn_reg;
`else
  // Default build: no noisy-coefficient output and no storage for it.
`endif

endmodule

// File: tb/tb_decrypt_ctrl.sv
// tb_decrypt_ctrl -- self-checking bench for decrypt_ctrl. Expected results
// come from a polynomial-arithmetic model of v - sum(s_r*u_r) mod (x^4+1, Q).
module tb_decrypt_ctrl;

  localparam int Q      = 17;
  localparam int RND_LO = 5;
  localparam int RND_HI = 13;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic signed [31:0] secret_key [1:0][3:0];
  logic signed [31:0] ciphertext [1:0][1:0][3:0];
  logic [3:0] m_b, decimal_value;
`ifdef DECRYPT_CTRL_NOISY_OUT_EN
  logic [4:0] mn_out [3:0];
`endif

  int checks = 0;
  int fails  = 0;

  int sk [2][4];
  int uu [2][4];
  int vv [4];
  int exp_mn [4];
  logic [3:0] exp_mb;
  int exp_dec;

  logic [3:0] spec_mb  [4] = '{4'b0101, 4'b1111, 4'b0001, 4'b0011};
  int         spec_dec [4] = '{10, 15, 8, 12};

  decrypt_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .secret_key(secret_key), .ciphertext(ciphertext),
    .out_valid(out_valid), .out_ready(out_ready),
    .m_b(m_b), .decimal_value(decimal_value)
`ifdef DECRYPT_CTRL_NOISY_OUT_EN
    , .mn_out(mn_out)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int tmod(input longint x);
    longint r;
    r = x % Q;
    if (r < 0) r += Q;
    return int'(r);
  endfunction

  // mn = v - sum_r s_r*u_r in Z_Q[x]/(x^4+1); x^a * x^b = -x^(a+b-4) when a+b>=4.
  function automatic void compute_model();
    longint acc;
    for (int c = 0; c < 4; c++) begin
      acc = tmod(vv[c]);
      for (int r = 0; r < 2; r++)
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 4; b++)
            if ((a + b) % 4 == c) begin
              if (a + b >= 4) acc += tmod(sk[r][a]) * tmod(uu[r][b]);
              else            acc -= tmod(sk[r][a]) * tmod(uu[r][b]);
            end
      exp_mn[c] = tmod(acc);
      exp_mb[c] = (exp_mn[c] >= RND_LO) && (exp_mn[c] <= RND_HI);
    end
    exp_dec = 8 * exp_mb[0] + 4 * exp_mb[1] + 2 * exp_mb[2] + exp_mb[3];
  endfunction

  function automatic int rand_coeff();
    case ($urandom_range(0, 2))
      0:       return int'($urandom);
      1:       return int'($urandom_range(0, 40)) - 20;
      default: return int'($urandom_range(0, 16));
    endcase
  endfunction

  task automatic clear_stim();
    for (int n = 0; n < 4; n++) begin
      vv[n] = 0;
      for (int r = 0; r < 2; r++) begin
        sk[r][n] = 0;
        uu[r][n] = 0;
      end
    end
  endtask

  task automatic random_stim();
    for (int n = 0; n < 4; n++) begin
      vv[n] = rand_coeff();
      for (int r = 0; r < 2; r++) begin
        sk[r][n] = rand_coeff();
        uu[r][n] = rand_coeff();
      end
    end
  endtask

  task automatic drive_inputs();
    for (int n = 0; n < 4; n++) begin
      for (int r = 0; r < 2; r++) begin
        secret_key[r][n]    = sk[r][n];
        ciphertext[0][r][n] = uu[r][n];
      end
      ciphertext[1][0][n] = vv[n];
      ciphertext[1][1][n] = $urandom;
    end
  endtask

  task automatic scramble_inputs();
    for (int n = 0; n < 4; n++) begin
      for (int r = 0; r < 2; r++) begin
        secret_key[r][n]    = $urandom;
        ciphertext[0][r][n] = $urandom;
      end
      ciphertext[1][0][n] = $urandom;
      ciphertext[1][1][n] = $urandom;
    end
  endtask

  // Starts in IDLE just after an edge; handshakes and counts edges until
  // out_valid. in_valid stays high with junk inputs meanwhile (must be ignored).
  task automatic do_request(output int lat);
    drive_inputs();
    in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      scramble_inputs();
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    clear_stim(); drive_inputs();
    #12;
    checks += 4;
    if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (m_b !== 4'd0)       begin fails++; $display("FAIL reset_m_b: got %b want 0000", m_b); end
    if (decimal_value !== 4'd0) begin fails++; $display("FAIL reset_dec: got %0d want 0", decimal_value); end
`ifdef DECRYPT_CTRL_NOISY_OUT_EN
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (mn_out[n] !== 5'd0) begin fails++; $display("FAIL reset_mn_out[%0d]: got %0d want 0", n, mn_out[n]); end
    end
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    $display("test_reset: done");
  endtask

  task automatic test_vectors();
    int lat;
    for (int t = 0; t < 4; t++) begin
      clear_stim();
      case (t)
        0: vv = '{9, 0, 9, 0};
        1: begin sk[0][0] = 1; for (int b = 0; b < 4; b++) uu[0][b] = 9; end
        2: begin sk[0][1] = 1; uu[0][3] = 9; end
        default: vv = '{-8, -25, 4, 14};
      endcase
      compute_model();
      do_request(lat);
      checks += 3;
      if (lat != 34) begin fails++; $display("FAIL vec%0d_latency: got %0d want 34", t, lat); end
      if (m_b !== spec_mb[t]) begin fails++; $display("FAIL vec%0d_m_b: got %b want %b", t, m_b, spec_mb[t]); end
      if (decimal_value !== 4'(spec_dec[t])) begin fails++; $display("FAIL vec%0d_dec: got %0d want %0d", t, decimal_value, spec_dec[t]); end
`ifdef DECRYPT_CTRL_NOISY_OUT_EN
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (mn_out[n] !== 5'(exp_mn[n])) begin fails++; $display("FAIL vec%0d_mn_out[%0d]: got %0d want %0d", t, n, mn_out[n], exp_mn[n]); end
      end
`endif
      release_result();
      checks += 3;
      if (in_ready !== 1'b1)  begin fails++; $display("FAIL vec%0d_idle_in_ready: got %b want 1", t, in_ready); end
      if (out_valid !== 1'b0) begin fails++; $display("FAIL vec%0d_idle_out_valid: got %b want 0", t, out_valid); end
      if (m_b !== spec_mb[t]) begin fails++; $display("FAIL vec%0d_m_b_hold: got %b want %b", t, m_b, spec_mb[t]); end
      $display("test_vectors: vector %0d latency %0d m_b %b dec %0d", t, lat, m_b, decimal_value);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    random_stim();
    compute_model();
    do_request(lat);
    checks++;
    if (lat != 34) begin fails++; $display("FAIL bp_latency: got %0d want 34", lat); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks += 4;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid c%0d: got %b want 1", c, out_valid); end
      if (in_ready !== 1'b0)  begin fails++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
      if (m_b !== exp_mb)     begin fails++; $display("FAIL bp_m_b c%0d: got %b want %b", c, m_b, exp_mb); end
      if (decimal_value !== 4'(exp_dec)) begin fails++; $display("FAIL bp_dec c%0d: got %0d want %0d", c, decimal_value, exp_dec); end
    end
    release_result();
    checks += 2;
    if (in_ready !== 1'b1)  begin fails++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
    $display("test_backpressure: held 10 cycles, m_b %b dec %0d", m_b, decimal_value);
  endtask

  task automatic test_reset_mid_mac();
    int lat, seen;
    random_stim(); drive_inputs();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1)  begin fails++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    if (m_b !== 4'd0)       begin fails++; $display("FAIL rst_mid_m_b: got %b want 0000", m_b); end
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin fails++; $display("FAIL rst_mid_discard: out_valid seen %0d cycles want 0", seen); end
    clear_stim();
    vv = '{-8, -25, 4, 14};
    compute_model();
    do_request(lat);
    checks += 3;
    if (lat != 34) begin fails++; $display("FAIL rst_after_latency: got %0d want 34", lat); end
    if (m_b !== 4'b0011) begin fails++; $display("FAIL rst_after_m_b: got %b want 0011", m_b); end
    if (decimal_value !== 4'd12) begin fails++; $display("FAIL rst_after_dec: got %0d want 12", decimal_value); end
    release_result();
    $display("test_reset_mid_mac: recovered, m_b %b dec %0d", m_b, decimal_value);
  endtask

  task automatic test_random();
    int lat;
    for (int t = 0; t < 25; t++) begin
      random_stim();
      compute_model();
      do_request(lat);
      checks += 3;
      if (lat != 34) begin fails++; $display("FAIL rnd%0d_latency: got %0d want 34", t, lat); end
      if (m_b !== exp_mb) begin fails++; $display("FAIL rnd%0d_m_b: got %b want %b", t, m_b, exp_mb); end
      if (decimal_value !== 4'(exp_dec)) begin fails++; $display("FAIL rnd%0d_dec: got %0d want %0d", t, decimal_value, exp_dec); end
`ifdef DECRYPT_CTRL_NOISY_OUT_EN
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (mn_out[n] !== 5'(exp_mn[n])) begin fails++; $display("FAIL rnd%0d_mn_out[%0d]: got %0d want %0d", t, n, mn_out[n], exp_mn[n]); end
      end
`endif
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      release_result();
      checks++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL rnd%0d_in_ready: got %b want 1", t, in_ready); end
      $display("test_random: txn %0d m_b %b dec %0d expected %b/%0d", t, m_b, decimal_value, exp_mb, exp_dec);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      random_stim();
      compute_model();
      do_request(lat);
      checks += 3;
      if (lat != 34) begin fails++; $display("FAIL b2b%0d_latency: got %0d want 34", t, lat); end
      if (m_b !== exp_mb) begin fails++; $display("FAIL b2b%0d_m_b: got %b want %b", t, m_b, exp_mb); end
      if (decimal_value !== 4'(exp_dec)) begin fails++; $display("FAIL b2b%0d_dec: got %0d want %0d", t, decimal_value, exp_dec); end
      // in_valid is high across the releasing edge; it must not be taken in DONE.
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks += 2;
      if (in_ready !== 1'b1)  begin fails++; $display("FAIL b2b%0d_in_ready: got %b want 1", t, in_ready); end
      if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b%0d_out_valid: got %b want 0", t, out_valid); end
      $display("test_back_to_back: txn %0d m_b %b dec %0d", t, m_b, decimal_value);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_mac();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/decrypt_ctrl.md
DECRYPT_CTRL -- requirements
Module: decrypt_ctrl

Interface
REQ-001 SHALL have parameter Q, default 17: the ciphertext modulus.
REQ-002 SHALL have parameter RND_LO, default 5: lowest reduced coefficient that decodes to 1.
REQ-003 SHALL have parameter RND_HI, default 13: highest reduced coefficient that decodes to 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: the request to decrypt is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-008 SHALL have port secret_key, input, signed 32 bits, unpacked [1:0][3:0]: s_r, coefficient index [3:0].
REQ-009 SHALL have port ciphertext, input, signed 32 bits, unpacked [1:0][1:0][3:0]:
- [0][r] is u_r.
- [1][0] is v.
- [1][1] is ignored.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port m_b, output, 4 bits: the decoded message bits.
REQ-013 SHALL have port decimal_value, output, 4 bits: decimal_value = 8*m_b[0] + 4*m_b[1] + 2*m_b[2] + m_b[3].

Function
REQ-014 SHALL compute mn = v - (s_0*u_0 + s_1*u_1) in Z_Q[x]/(x^4+1), using one shared multiply-accumulate unit.
REQ-015 SHALL have FSM states IDLE, MAC, REDUCE, DONE.
REQ-016 SHALL drive in_ready high only in IDLE.
REQ-017 SHALL capture on a handshake (in_valid && in_ready), then go to MAC.
- Every input coefficient is reduced to [0,Q-1] with true modulo, so negative inputs map correctly.
- The accumulator is loaded with reduced v.
REQ-018 SHALL perform one MAC per cycle in MAC, for 32 cycles, with counters r (0..1) outer, i (0..3), j (0..3) inner.
- Each cycle computes the product p = s_r[j]*u_r[i] and the index k = i+j.
- When k<4: acc[k] -= p.
- When k>=4: acc[k-4] += p (negacyclic wrap).
REQ-019 SHALL hold signed 16-bit accumulators, which SHALL NOT overflow for reduced inputs.
REQ-020 SHALL spend one cycle in REDUCE:
- Each acc[k] is reduced to [0,Q-1] with true modulo.
- m_b[k] = 1 when RND_LO <= reduced <= RND_HI, else 0.
- m_b and decimal_value are registered.
REQ-021 SHALL raise out_valid in DONE exactly 34 cycles after the handshake edge.
REQ-022 SHALL hold out_valid, m_b and decimal_value stable in DONE until out_ready is high.
REQ-023 SHALL go to IDLE on the cycle after out_valid && out_ready, with in_ready high that cycle.
REQ-024 SHALL ignore in_valid outside IDLE, and SHALL NOT accept while out_valid is high.
REQ-025 SHALL hold m_b and decimal_value at their last result while not in DONE.

Reset
REQ-026 SHALL, while rst is high, immediately and asynchronously force:
- state to IDLE;
- counters, accumulators, m_b and decimal_value to 0;
- out_valid to 0;
- in_ready to 1 after release.
REQ-027 SHALL, on a reset mid-MAC or in DONE, discard the operation with no result emitted.

Configuration
REQ-028 SHALL, with DECRYPT_CTRL_NOISY_OUT_EN defined, add output port mn_out, unsigned 5 bits, unpacked [3:0].
- mn_out carries the reduced noisy coefficients.
- It is registered in REDUCE, valid with out_valid, and reset to 0.
REQ-029 SHALL, without DECRYPT_CTRL_NOISY_OUT_EN, have no mn_out port or registers, with all other behaviour identical.

Structure
REQ-030 SHALL take from the shared package baby_kyber_pkg:
- constants Q, N=4, K=2, RND_LO, RND_HI;
- typedef coeff_t (signed 32-bit);
- typedef acc_t (signed 16-bit);
- the state enum.
REQ-031 SHALL use one combinational sub-module, coeff_mod_q, for true-modulo reduction; it is used at capture and at REDUCE.

Verification
REQ-032 SHALL pass: s=0, v={9,0,9,0} (index 0..3) -> m_b=4'b0101, decimal_value=10, out_valid at cycle 34.
REQ-033 SHALL pass: s_0={1,0,0,0}, u_0={9,9,9,9}, s_1=0, v=0 -> mn=8 for all coefficients, m_b=4'b1111, decimal_value=15.
REQ-034 SHALL pass the wrap case: s_0={0,1,0,0}, u_0={0,0,0,9}, s_1=0, v=0 -> mn={9,0,0,0}, decimal_value=8.
REQ-035 SHALL pass: v={-8,-25,4,14}, s=0 -> reduced {9,9,4,14}, m_b=4'b0011, decimal_value=12.
REQ-036 SHALL pass: out_ready held low 10 cycles in DONE -> out_valid and outputs stable, in_ready low; out_ready high -> in_ready high the next cycle.
REQ-037 SHALL pass: rst pulsed 10 cycles into MAC -> out_valid 0 and in_ready 1; a following request returns the correct result.
